branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 17 +
 rtl/br_cond_eval.sv | 29 ++
 rtl/branch_resolve_unit.sv | 126 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: branch condition codes and
// 2-bit saturating predictor counter encodings.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator. funct3 010/011 flag illegal.
module br_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    output logic            cond,
    output logic            illegal
);

    // Decode the condition code and compare the operands.
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (A == B);
            F3_BNE:  cond = (A != B);
            F3_BLT:  cond = ($signed(A) <  $signed(B));
            F3_BGE:  cond = ($signed(A) >= $signed(B));
            F3_BLTU: cond = (A <  B);
            F3_BGEU: cond = (A >= B);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches, trains a 2-bit
// branch history table and keeps saturating resolve/mispredict statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              Branch,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic [XLEN-1:0]   res_pc,
    input  logic              res_pred_taken,
    output logic              BrTaken,
    output logic              res_done,
    output logic              mispredict,
    output logic              illegal_br,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        bht_q [BHT_DEPTH];
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  res_idx;
    logic              cond;
    logic              f3_illegal;
    logic              upd_en;
    logic              taken_d;
    logic              mp_d;
    logic [1:0]        ctr_cur;
    logic [1:0]        ctr_nxt;
    logic              br_taken_q;
    logic              res_done_q;
    logic              mispredict_q;
    logic              illegal_br_q;
    logic [STAT_W-1:0] br_count_q;
    logic [STAT_W-1:0] mp_count_q;
    logic              unused_pc;

    // Only the index bits of the PCs select an entry; the rest alias.
    assign pred_idx  = pred_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];
    assign unused_pc = ^{pred_pc, res_pc};

    br_cond_eval #(
        .XLEN(XLEN)
    ) u_cond_eval (
        .A      (A),
        .B      (B),
        .funct3 (funct3),
        .cond   (cond),
        .illegal(f3_illegal)
    );

    // Table read is the registered state, so a same-cycle update is not visible.
    assign pred_taken = pred_valid & bht_q[pred_idx][1];

    // Resolved direction, mispredict flag and saturating next counter value.
    always_comb begin
        upd_en  = res_valid & Branch & ~f3_illegal;
        taken_d = Branch & ~f3_illegal & cond;
        mp_d    = taken_d ^ res_pred_taken;
        ctr_cur = bht_q[res_idx];
        ctr_nxt = ctr_cur;
        if (taken_d) begin
            if (ctr_cur != ST) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != SNT) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    // Branch history table, reset to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= WNT;
        end else if (upd_en) begin
            bht_q[res_idx] <= ctr_nxt;
        end
    end

    // Resolution outputs, valid for one cycle after an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_taken_q   <= 1'b0;
            res_done_q   <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_br_q <= 1'b0;
        end else begin
            res_done_q <= res_valid;
            if (res_valid) begin
                br_taken_q   <= taken_d;
                mispredict_q <= mp_d;
                illegal_br_q <= Branch & f3_illegal;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else if (upd_en) begin
            if (br_count_q != {STAT_W{1'b1}}) br_count_q <= br_count_q + STAT_W'(1);
            if (mp_d && (mp_count_q != {STAT_W{1'b1}})) mp_count_q <= mp_count_q + STAT_W'(1);
        end
    end

    assign BrTaken    = br_taken_q;
    assign res_done   = res_done_q;
    assign mispredict = mispredict_q;
    assign illegal_br = illegal_br_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with a behavioural predictor model.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BHT_DEPTH = 16;
    localparam int unsigned STAT_W    = 4;
    localparam int          STAT_MAX  = 15;

    typedef struct {
        logic taken;
        logic misp;
        logic illegal;
        int   brc;
        int   mpc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pred_valid = 1'b0;
    logic [XLEN-1:0]   pred_pc = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic              Branch = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [XLEN-1:0]   A = '0;
    logic [XLEN-1:0]   B = '0;
    logic [XLEN-1:0]   res_pc = '0;
    logic              res_pred_taken = 1'b0;
    logic              BrTaken;
    logic              res_done;
    logic              mispredict;
    logic              illegal_br;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] mp_count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    int   m_bht[BHT_DEPTH];
    int   m_brc;
    int   m_mpc;

    branch_resolve_unit #(
        .XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .res_valid(res_valid), .Branch(Branch), .funct3(funct3),
        .A(A), .B(B), .res_pc(res_pc), .res_pred_taken(res_pred_taken), .BrTaken(BrTaken),
        .res_done(res_done), .mispredict(mispredict), .illegal_br(illegal_br),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % BHT_DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(BHT_DEPTH); i++) m_bht[i] = 1;
        m_brc = 0;
        m_mpc = 0;
        sb_q.delete();
    endtask

    // Monitor: every res_done pulse must match the oldest expected resolution.
    always @(negedge clk) begin
        if (!rst && res_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_res_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("BrTaken", BrTaken, e.taken);
                chk("mispredict", mispredict, e.misp);
                chk("illegal_br", illegal_br, e.illegal);
                chk("br_count", br_count, e.brc);
                chk("mp_count", mp_count, e.mpc);
            end
        end
    end

    // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cyc(input logic rv, input logic br, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc, input logic pt,
                       input logic pv, input logic [XLEN-1:0] ppc, input bit push);
        bit   legal, c, upd, tk;
        exp_t e;
        res_valid = rv; Branch = br; funct3 = f3; A = a; B = b;
        res_pc = pc; res_pred_taken = pt; pred_valid = pv; pred_pc = ppc;
        #2;
        chk("pred_taken", pred_taken, (pv && m_bht[idx_of(ppc)] >= 2) ? 1 : 0);
        if (rv && push) begin
            legal = 1'b1;
            c     = 1'b0;
            case (f3)
                3'd0: c = (a == b);
                3'd1: c = (a != b);
                3'd4: c = ($signed(a) < $signed(b));
                3'd5: c = ($signed(a) >= $signed(b));
                3'd6: c = (a < b);
                3'd7: c = (a >= b);
                default: legal = 1'b0;
            endcase
            upd = br && legal;
            tk  = upd && c;
            if (upd) begin
                if (tk) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] < 3) ? m_bht[idx_of(pc)] + 1 : 3;
                else    m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] > 0) ? m_bht[idx_of(pc)] - 1 : 0;
                if (m_brc < STAT_MAX) m_brc++;
                if (tk != pt && m_mpc < STAT_MAX) m_mpc++;
            end
            e.taken = tk; e.misp = (tk != pt); e.illegal = br && !legal;
            e.brc = m_brc; e.mpc = m_mpc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc, input logic pt);
        cyc(1'b1, 1'b1, f3, a, b, pc, pt, 1'b0, '0, 1'b1);
    endtask

    task automatic look(input logic [XLEN-1:0] ppc);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b1, ppc, 1'b1);
    endtask

    task automatic do_reset();
        res_valid = 1'b0; pred_valid = 1'b0; Branch = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt;
        model_reset();
        do_reset();

        // Reset state.
        #2;
        chk("reset_res_done", res_done, 0);
        chk("reset_br_count", br_count, 0);
        chk("reset_mp_count", mp_count, 0);
        @(posedge clk);
        #1;
        look(32'h0); look(32'h40); look(32'h3C); look(32'hFFFF_FFFC);

        // Condition sweep.
        res(3'b100, 32'hFFFF_FFFB, 32'd3, 32'h100, 1'b0);
        res(3'b110, 32'hFFFF_FFFE, 32'd1, 32'h104, 1'b0);
        res(3'b001, 32'd8, 32'd8, 32'h108, 1'b0);
        res(3'b101, 32'd3, 32'hFFFF_FFFB, 32'h10C, 1'b1);
        res(3'b111, 32'd1, 32'hFFFF_FFFE, 32'h110, 1'b1);
        res(3'b000, 32'd7, 32'd7, 32'h114, 1'b1);

        // Training at 0x40 then collision with aliasing 0x80.
        do_reset();
        res(3'b000, 32'd10, 32'd10, 32'h40, 1'b0);
        res(3'b000, 32'd10, 32'd10, 32'h40, 1'b0);
        #1;
        chk("train_mp_count", mp_count, 2);
        look(32'h40);
        repeat (4) res(3'b000, 32'd10, 32'd11, 32'h40, 1'b1);
        look(32'h40);
        res(3'b000, 32'd1, 32'd1, 32'h40, 1'b0);
        cyc(1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b1);
        look(32'h80);

        // Illegal funct3 and non-branch.
        cyc(1'b1, 1'b1, 3'b010, 32'd5, 32'd5, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1);
        cyc(1'b1, 1'b1, 3'b011, 32'd5, 32'd5, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1);
        cyc(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1);
        look(32'h80);

        // Randomized mix, back-to-back where res_valid lands in consecutive cycles.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] a, b;
            logic [2:0] f3;
            a  = ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 6)) - 32'd3 : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a
                 : (($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 6)) - 32'd3 : $urandom);
            f3 = 3'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0), f3, a, b,
                XLEN'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), XLEN'($urandom_range(0, 63)) << 2, 1'b1);
            if (i == 150) do_reset();
        end

        // Reset while a resolution is in flight: no res_done pulse.
        cyc(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b1, 3'b000, 32'd2, 32'd2, 32'h40, 1'b0, 1'b0, '0, 1'b0);
        res_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_res_done", res_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("post_rst_res_done", res_done, 0);
        chk("post_rst_br_count", br_count, 0);
        @(posedge clk);
        #1;
        look(32'h40);

        // Statistics saturation.
        for (int i = 0; i < 20; i++) res(3'b000, 32'd4, 32'd4, XLEN'(i) << 2, 1'b0);
        #1;
        chk("sat_br_count", br_count, 15);
        chk("sat_mp_count", mp_count, 15);

        cnt = 0;
        res_valid = 1'b0;
        while (sb_q.size() != 0 && cnt < 10) begin
            @(posedge clk);
            cnt++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
